// File: rtl/eth_rx_framer.sv
// MII receive framer: strips preamble/SFD, steers the nibble CRC checker,
// packs nibbles into bytes and reports a one-cycle end-of-frame status word.
module eth_rx_framer #(
   parameter int MIN_FRAME = 64,
   parameter int MAX_FRAME = 1518,
   parameter int MIN_PRE   = 2
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        MRxDV,
   input  logic [3:0]  MRxD,
   input  logic        MRxErr,
   input  logic        CrcError,
   output logic [3:0]  CrcData,
   output logic        CrcEnable,
   output logic        CrcInit,
   output logic [7:0]  RxData,
   output logic        RxValid,
   output logic        RxSof,
   output logic        RxEof,
   output logic [10:0] RxLen,
   output logic        RxGood,
   output logic [4:0]  RxStatus
);

   typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

   localparam logic [10:0] MIN_LEN  = 11'(MIN_FRAME);
   localparam logic [10:0] MAX_LEN  = 11'(MAX_FRAME);
   localparam logic [3:0]  PRE_MIN  = 4'(MIN_PRE);
   localparam logic [10:0] LEN_SAT  = 11'h7FF;
   localparam logic [3:0]  NIB_PRE  = 4'h5;
   localparam logic [3:0]  NIB_SFD  = 4'hD;

   state_t      state;
   logic        armed;
   logic [3:0]  pre_cnt;
   logic        nib_odd;
   logic [3:0]  low_nib;
   logic        phy_err;
   logic [4:0]  end_status;

   assign CrcData   = MRxD;
   assign CrcEnable = (state == DATA) & MRxDV;
   assign CrcInit   = (state == IDLE) | (state == PRE);

   // Status word as seen in the end cycle; CrcError is only meaningful here.
   assign end_status = {(RxLen > MAX_LEN),
                        (RxLen < MIN_LEN),
                        nib_odd,
                        (phy_err | MRxErr),
                        CrcError};

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state    <= IDLE;
         armed    <= 1'b0;
         pre_cnt  <= 4'd0;
         nib_odd  <= 1'b0;
         low_nib  <= 4'd0;
         phy_err  <= 1'b0;
         RxData   <= 8'd0;
         RxValid  <= 1'b0;
         RxSof    <= 1'b0;
         RxEof    <= 1'b0;
         RxLen    <= 11'd0;
         RxGood   <= 1'b0;
         RxStatus <= 5'd0;
      end else begin
         RxValid <= 1'b0;
         RxSof   <= 1'b0;
         RxEof   <= 1'b0;
         RxGood  <= 1'b0;
         if (!MRxDV) begin
            armed <= 1'b1;
         end

         case (state)
            IDLE: begin
               // Only start after a quiet cycle, so a reset mid-frame cannot
               // mistake payload nibbles for a preamble.
               if (armed && MRxDV && (MRxD == NIB_PRE)) begin
                  state    <= PRE;
                  pre_cnt  <= 4'd1;
                  nib_odd  <= 1'b0;
                  phy_err  <= 1'b0;
                  RxLen    <= 11'd0;
                  RxStatus <= 5'd0;
               end
            end

            PRE: begin
               if (!MRxDV) begin
                  state <= IDLE;
               end else if (MRxD == NIB_PRE) begin
                  if (pre_cnt != 4'hF) begin
                     pre_cnt <= pre_cnt + 4'd1;
                  end
               end else if ((MRxD == NIB_SFD) && (pre_cnt >= PRE_MIN)) begin
                  state <= DATA;
               end else begin
                  state <= DROP;
               end
            end

            DATA: begin
               if (MRxErr) begin
                  phy_err <= 1'b1;
               end
               if (MRxDV) begin
                  nib_odd <= ~nib_odd;
                  if (!nib_odd) begin
                     low_nib <= MRxD;
                  end else begin
                     RxData  <= {MRxD, low_nib};
                     RxValid <= 1'b1;
                     RxSof   <= (RxLen == 11'd0);
                     if (RxLen != LEN_SAT) begin
                        RxLen <= RxLen + 11'd1;
                     end
                  end
               end else begin
                  state    <= IDLE;
                  RxEof    <= 1'b1;
                  RxStatus <= end_status;
                  RxGood   <= ~|end_status;
               end
            end

            DROP: begin
               if (!MRxDV) begin
                  state <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_eth_rx_framer.sv
// Randomized scoreboard bench for eth_rx_framer with a behavioural CRC checker
// and a frame-level reference model.
module tb_eth_rx_framer;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        MRxDV = 1'b0;
   logic [3:0]  MRxD = 4'd0;
   logic        MRxErr = 1'b0;
   logic        CrcError;
   logic [3:0]  CrcData;
   logic        CrcEnable;
   logic        CrcInit;
   logic [7:0]  RxData;
   logic        RxValid;
   logic        RxSof;
   logic        RxEof;
   logic [10:0] RxLen;
   logic        RxGood;
   logic [4:0]  RxStatus;

   eth_rx_framer #(.MIN_FRAME(64), .MAX_FRAME(1518), .MIN_PRE(2)) dut (
      .Clk(Clk), .Reset(Reset), .MRxDV(MRxDV), .MRxD(MRxD), .MRxErr(MRxErr),
      .CrcError(CrcError), .CrcData(CrcData), .CrcEnable(CrcEnable), .CrcInit(CrcInit),
      .RxData(RxData), .RxValid(RxValid), .RxSof(RxSof), .RxEof(RxEof),
      .RxLen(RxLen), .RxGood(RxGood), .RxStatus(RxStatus)
   );

   always #5 Clk = ~Clk;

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   int checks = 0;
   int passes = 0;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endfunction

   // Reflected CRC-32 over one nibble, LSB first.
   function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] d);
      logic [31:0] r;
      r = c;
      for (int b = 0; b < 4; b++) begin
         if (r[0] ^ d[b]) r = (r >> 1) ^ 32'hEDB88320;
         else             r = r >> 1;
      end
      return r;
   endfunction

   localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

   // CRC checker model: scrambles its register whenever neither init nor enable.
   logic [31:0] crc_reg;
   always @(posedge Clk or posedge Reset) begin
      if (Reset)          crc_reg <= 32'hFFFFFFFF;
      else if (CrcInit)   crc_reg <= 32'hFFFFFFFF;
      else if (CrcEnable) crc_reg <= crc_nib(crc_reg, CrcData);
      else                crc_reg <= {crc_reg[30:0], ~crc_reg[31]};
   end
   assign CrcError = (crc_reg != RESIDUE);

   typedef struct {
      logic [7:0] data;
      logic       sof;
      int         at;
   } byte_exp_t;

   typedef struct {
      logic [10:0] len;
      logic [4:0]  status;
      logic        good;
      int          at;
   } eof_exp_t;

   byte_exp_t bq[$];
   eof_exp_t  eq[$];

   always @(negedge Clk) begin : monitor
      byte_exp_t be;
      eof_exp_t  ee;
      if (!Reset) begin
         check("crc_data_copy", 32'(CrcData), 32'(MRxD));
         if (RxValid || RxEof) check("valid_eof_overlap", 32'(RxValid & RxEof), 32'd0);
         if (RxValid) begin
            if (bq.size() == 0) begin
               check("unexpected_byte", 32'(RxData), 32'hFFFF_FFFF);
            end else begin
               be = bq.pop_front();
               check("byte_data", 32'(RxData), 32'(be.data));
               check("byte_sof", 32'(RxSof), 32'(be.sof));
               check("byte_cycle", 32'(cyc), 32'(be.at));
            end
         end
         if (RxEof) begin
            if (eq.size() == 0) begin
               check("unexpected_eof", 32'(RxLen), 32'hFFFF_FFFF);
            end else begin
               ee = eq.pop_front();
               check("eof_len", 32'(RxLen), 32'(ee.len));
               check("eof_status", 32'(RxStatus), 32'(ee.status));
               check("eof_good", 32'(RxGood), 32'(ee.good));
               check("eof_cycle", 32'(cyc), 32'(ee.at));
            end
         end
      end
   end

   task automatic drive(input logic dv, input logic [3:0] d, input logic err);
      @(negedge Clk);
      MRxDV  = dv;
      MRxD   = d;
      MRxErr = err;
   endtask

   // Builds a frame, pushes the expected response, then drives it.
   task automatic send_frame(input int npre, input bit bad_sfd, input int npay,
                             input bit corrupt, input bit extra, input int err_at,
                             input bit a7, input int gap);
      logic [7:0]  frm[$];
      logic [3:0]  dn[$];
      logic [31:0] c;
      logic [31:0] fcs;
      logic [7:0]  m;
      logic [4:0]  st;
      logic [10:0] len_e;
      byte_exp_t   be;
      eof_exp_t    ee;
      bit          accept;
      int          nb;
      int          idx;

      for (int i = 0; i < npay; i++) frm.push_back(8'($urandom));
      if (a7) frm[0] = 8'hA7;
      c = 32'hFFFFFFFF;
      for (int i = 0; i < npay; i++) begin
         c = crc_nib(c, frm[i][3:0]);
         c = crc_nib(c, frm[i][7:4]);
      end
      fcs = ~c;
      frm.push_back(fcs[7:0]);
      frm.push_back(fcs[15:8]);
      frm.push_back(fcs[23:16]);
      frm.push_back(fcs[31:24]);
      if (corrupt) begin
         idx = $urandom_range(0, npay - 1);
         m = 8'h01 << $urandom_range(0, 7);
         frm[idx] = frm[idx] ^ m;
      end
      foreach (frm[i]) begin
         dn.push_back(frm[i][3:0]);
         dn.push_back(frm[i][7:4]);
      end
      if (extra) dn.push_back(4'($urandom));

      accept = !bad_sfd && (npre >= 2);
      c = 32'hFFFFFFFF;
      foreach (dn[i]) c = crc_nib(c, dn[i]);
      nb = dn.size() / 2;
      len_e = (nb > 2047) ? 11'd2047 : 11'(nb);
      st = {(nb > 1518), (nb < 64), ((dn.size() % 2) == 1), (err_at >= 0), (c != RESIDUE)};

      for (int i = 0; i < npre; i++) drive(1'b1, 4'h5, 1'b0);
      drive(1'b1, bad_sfd ? 4'h3 : 4'hD, 1'b0);
      foreach (dn[i]) begin
         drive(1'b1, dn[i], (i == err_at));
         if (accept && (i % 2 == 1)) begin
            be.data = {dn[i], dn[i-1]};
            be.sof  = (i == 1);
            be.at   = cyc + 1;
            bq.push_back(be);
         end
      end
      drive(1'b0, 4'($urandom), 1'b0);
      if (accept) begin
         ee.len    = len_e;
         ee.status = st;
         ee.good   = (st == 5'd0);
         ee.at     = cyc + 1;
         eq.push_back(ee);
      end
      for (int g = 1; g < gap; g++) drive(1'b0, 4'($urandom), 1'b0);
   endtask

   initial begin : watchdog
      repeat (60000) @(posedge Clk);
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      repeat (3) @(negedge Clk);
      check("rst_rxdata", 32'(RxData), 32'd0);
      check("rst_valid_sof_eof_good", 32'({RxValid, RxSof, RxEof, RxGood}), 32'd0);
      check("rst_rxlen", 32'(RxLen), 32'd0);
      check("rst_status", 32'(RxStatus), 32'd0);
      check("rst_crcinit", 32'(CrcInit), 32'd1);
      check("rst_crcenable", 32'(CrcEnable), 32'd0);
      Reset = 1'b0;
      repeat (3) drive(1'b0, 4'h0, 1'b0);

      send_frame(15, 0, 60, 0, 0, -1, 0, 3);    // minimum good frame
      send_frame(15, 0, 60, 1, 0, -1, 0, 3);    // corrupted payload bit
      send_frame(8, 0, 70, 0, 0, -1, 1, 2);     // 0xA7 nibble order
      send_frame(8, 0, 1515, 0, 0, -1, 0, 2);   // 1519 bytes, too long
      send_frame(8, 0, 36, 0, 0, -1, 0, 2);     // 40 bytes, too short
      send_frame(8, 0, 61, 0, 1, -1, 0, 2);     // 65 bytes plus a stray nibble
      send_frame(8, 0, 70, 0, 0, 30, 0, 2);     // PHY error mid-frame
      send_frame(7, 1, 64, 0, 0, -1, 0, 2);     // bad SFD: dropped
      send_frame(1, 0, 64, 0, 0, -1, 0, 2);     // preamble too short: dropped
      send_frame(2, 0, 60, 0, 0, -1, 0, 1);     // minimum preamble, 1-cycle gap
      send_frame(2, 0, 60, 0, 0, -1, 0, 1);     // back-to-back

      // Reset in the middle of DATA with MRxDV held high.
      repeat (6) drive(1'b1, 4'h5, 1'b0);
      drive(1'b1, 4'hD, 1'b0);
      drive(1'b1, 4'h2, 1'b0);
      drive(1'b1, 4'h1, 1'b0);
      begin
         byte_exp_t be;
         be.data = 8'h12;
         be.sof  = 1'b1;
         be.at   = cyc + 1;
         bq.push_back(be);
      end
      drive(1'b1, 4'h3, 1'b0);
      @(negedge Clk);
      #2 Reset = 1'b1;
      #1;
      check("midrst_rxlen", 32'(RxLen), 32'd0);
      check("midrst_flags", 32'({RxValid, RxSof, RxEof, RxGood}), 32'd0);
      check("midrst_rxdata", 32'(RxData), 32'd0);
      drive(1'b1, 4'h5, 1'b0);
      drive(1'b1, 4'h5, 1'b0);
      Reset = 1'b0;
      repeat (4) drive(1'b1, 4'h5, 1'b0);
      drive(1'b1, 4'hD, 1'b0);
      repeat (20) drive(1'b1, 4'($urandom), 1'b0);
      drive(1'b0, 4'h0, 1'b0);
      send_frame(4, 0, 64, 0, 0, -1, 0, 2);     // received normally after reset

      for (int k = 0; k < 8; k++) begin
         send_frame($urandom_range(2, 15), 0, $urandom_range(40, 120),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                    -1, 0, $urandom_range(1, 3));
      end

      repeat (5) drive(1'b0, 4'h0, 1'b0);
      check("bytes_outstanding", 32'(bq.size()), 32'd0);
      check("eofs_outstanding", 32'(eq.size()), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/eth_rx_framer.md
Name: eth_rx_framer

Overview:
- Receive-side MII framer that sits directly upstream of the nibble CRC checker.
- Strips preamble/SFD from the MII nibble stream, drives the CRC checker's Data/Enable/Initialize inputs, and packs nibbles into bytes for the downstream FIFO converter.
- At end of frame it samples the checker's CrcError and emits a one-cycle end-of-frame status word.

Parameters:
- MIN_FRAME, 64, minimum legal frame length in bytes (DA through FCS inclusive).
- MAX_FRAME, 1518, maximum legal frame length in bytes (DA through FCS inclusive).
- MIN_PRE, 2, minimum count of 0x5 preamble nibbles before SFD for the frame to be accepted.

Ports:
- Clk  in  1  MII receive clock; all logic on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- MRxDV  in  1  MII receive data valid.
- MRxD  in  4  MII receive nibble, LSB-first nibble order.
- MRxErr  in  1  MII receive error.
- CrcError  in  1  from CRC checker; 1 = residue is not the magic value.
- CrcData  out  4  nibble to CRC checker; combinational copy of MRxD.
- CrcEnable  out  1  CRC checker Enable.
- CrcInit  out  1  CRC checker Initialize.
- RxData  out  8  assembled byte.
- RxValid  out  1  RxData valid, one-cycle pulse per byte.
- RxSof  out  1  asserted together with RxValid on the first byte of the frame.
- RxEof  out  1  one-cycle end-of-frame pulse; status outputs are valid only in this cycle.
- RxLen  out  11  byte count of the frame (FCS included), saturates at 2047.
- RxGood  out  1  asserted with RxEof when no status flag is set.
- RxStatus  out  5  error flags: {LongErr, ShortErr, AlignErr, PhyErr, CrcErr}.

Behaviour:
- Reset values:
  - State = IDLE, Armed = 0.
  - All registered outputs = 0 (RxData, RxValid, RxSof, RxEof, RxLen, RxGood, RxStatus).
  - Nibble, preamble and byte counters = 0.
- Combinational outputs:
  - CrcEnable = (state==DATA) & MRxDV.
  - CrcInit = (state==IDLE) | (state==PRE).
  - Consequence: the CRC register is preset before the first data nibble.
- Armed flag:
  - Set on any cycle with MRxDV=0.
  - IDLE leaves only when Armed=1, so a reset asserted mid-frame never false-starts on a payload 0x5.
- States: IDLE, PRE, DATA, DROP.
  - IDLE -> PRE: Armed & MRxDV & MRxD==0x5. Preamble count = 1.
  - PRE, MRxDV & MRxD==0x5: increment preamble count, saturating at 15.
  - PRE, MRxDV & MRxD==0xD & count>=MIN_PRE: -> DATA. The next cycle's nibble is the first DA nibble.
  - PRE, any other nibble, or 0xD with count<MIN_PRE: -> DROP.
  - PRE, MRxDV=0: -> IDLE. No RxEof.
  - DATA, MRxDV=1:
    - Even nibble: latch into the low half.
    - Odd nibble: RxData <= {MRxD, low}; RxValid=1 next cycle.
    - RxSof=1 on the first byte.
    - RxLen increments, saturating at 2047.
    - Latency: 1 cycle from the odd (second) nibble to RxValid.
  - DATA, MRxErr=1: set the sticky PhyErr flag.
  - DATA, MRxDV=0 (end cycle E): the CRC register already holds the residue of every enabled nibble. In cycle E the framer samples CrcError and computes:
    - CrcErr = CrcError.
    - AlignErr = odd nibble count; the trailing nibble is dropped and not output.
    - ShortErr = RxLen < MIN_FRAME.
    - LongErr = RxLen > MAX_FRAME.
    - At edge E: state -> IDLE. In cycle E+1: RxEof=1, RxGood = ~|RxStatus, RxLen held.
  - CRC sampling window: CrcError must be sampled only in cycle E. With Enable low the checker register shifts, so later samples are invalid.
  - DROP -> IDLE when MRxDV=0. No outputs are produced for a dropped frame.
- RxEof vs RxValid: if the last byte completes in cycle E-1, RxValid is in cycle E and RxEof in E+1, so they never coincide.
- RxLen: cleared on IDLE -> PRE.
- Reset mid-DATA: outputs clear immediately. No RxEof is emitted for the truncated frame.
- Back-to-back frames with a 1-cycle MRxDV gap: must be accepted. Armed is set by the gap cycle.

Test Plan:
- Min frame: 0x5 x15, 0xD, then 60 payload bytes plus 4-byte FCS from the bench CRC model; CRC checker instantiated -> 64 RxValid pulses, RxSof on byte 0, RxEof with RxLen=64, RxStatus=0, RxGood=1.
- Same frame with one payload bit flipped -> RxEof, CrcErr=1, RxGood=0, RxLen=64.
- Nibble order: payload byte 0xA7 sent as nibbles 7 then A -> RxData=0xA7, one cycle after the A nibble.
- 1519-byte valid-CRC frame -> LongErr=1, RxLen=1519. 40-byte frame -> ShortErr=1, RxLen=40.
- Odd length (65 bytes + 1 extra nibble) -> AlignErr=1, RxLen=65, no byte produced for the extra nibble. MRxErr pulse mid-frame -> PhyErr=1.
- Bad preamble (0x5 x7, 0x3, ...) -> no RxValid, no RxEof. Reset in mid-DATA with MRxDV held high and payload containing 0x5,0xD -> no activity until MRxDV drops, then the next frame is received normally.
